// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback datapath for the 5-stage RV32I core.
// Holds load data across stalls, aligns loads and selects the register-file write value.
module mem_wb_stage #(
   parameter int         XLEN   = 32,
   parameter logic [6:0] NOP_OP = 7'b0010011
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            flush,
   input  logic [6:0]      MEM_op,
   input  logic [4:0]      MEM_rd,
   input  logic [2:0]      MEM_funct3,
   input  logic [XLEN-1:0] MEM_alu_out,
   input  logic [XLEN-1:0] MEM_pc4,
   input  logic [11:0]     MEM_CSR_imm,
   input  logic [XLEN-1:0] DM_dout,
   input  logic [XLEN-1:0] CSR_dout,
   output logic [6:0]      WB_op,
   output logic [4:0]      WB_rd,
   output logic [11:0]     WB_CSR_imm,
   output logic [XLEN-1:0] WB_wdata,
   output logic            WB_reg_we,
   output logic            WB_retire
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_I_ARTH = 7'b0010011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_CSR    = 7'b1110011;

   logic [XLEN-1:0] wb_alu_out;
   logic [XLEN-1:0] wb_pc4;
   logic [2:0]      wb_funct3;
   logic [XLEN-1:0] ld_hold;
   logic            ld_hold_valid;
   logic [XLEN-1:0] ld_word;
   logic [XLEN-1:0] ld_data;
   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         WB_op      <= NOP_OP;
         WB_rd      <= '0;
         WB_CSR_imm <= '0;
         wb_alu_out <= '0;
         wb_pc4     <= '0;
         wb_funct3  <= '0;
      end else if (!stall) begin
         WB_op      <= MEM_op;
         WB_rd      <= MEM_rd;
         WB_CSR_imm <= MEM_CSR_imm;
         wb_alu_out <= MEM_alu_out;
         wb_pc4     <= MEM_pc4;
         wb_funct3  <= MEM_funct3;
      end
   end

   // SRAM output is only valid in a load's first WB cycle; keep it while stalled.
   always_ff @(posedge clk) begin
      if (rst || flush || !stall) begin
         ld_hold_valid <= 1'b0;
      end else if (WB_op == OP_LOAD && !ld_hold_valid) begin
         ld_hold_valid <= 1'b1;
      end
   end

   // NOTE: the held data word needs no reset; it is never used unless
   // ld_hold_valid (which is reset) says it was written.
   always_ff @(posedge clk) begin
      if (!rst && !flush && stall && WB_op == OP_LOAD && !ld_hold_valid) begin
         ld_hold <= DM_dout;
      end
   end

   assign ld_word = ld_hold_valid ? ld_hold : DM_dout;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      ld_byte = ld_word[7:0];
      case (wb_alu_out[1:0])
         2'd1:    ld_byte = ld_word[15:8];
         2'd2:    ld_byte = ld_word[23:16];
         2'd3:    ld_byte = ld_word[31:24];
         default: ld_byte = ld_word[7:0];
      endcase
      ld_half = wb_alu_out[1] ? ld_word[31:16] : ld_word[15:0];

      ld_data = ld_word;
      case (wb_funct3)
         3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
         3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
         3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
         3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
         default: ld_data = ld_word;
      endcase
   end

   always_comb begin
      WB_wdata  = wb_alu_out;
      WB_reg_we = 1'b0;
      case (WB_op)
         OP_LOAD:         WB_wdata = ld_data;
         OP_JAL, OP_JALR: WB_wdata = wb_pc4;
         OP_CSR:          WB_wdata = CSR_dout;
         default:         WB_wdata = wb_alu_out;
      endcase
      case (WB_op)
         OP_LOAD, OP_I_ARTH, OP_R, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_CSR:
            WB_reg_we = (WB_rd != 5'd0);
         OP_STORE, OP_BRANCH:
            WB_reg_we = 1'b0;
         default:
            WB_reg_we = 1'b0;
      endcase
   end

   // Bubbles (addi x0,x0,0) never retire, matching the CSR unit's instret rule.
   assign WB_retire = !stall && !rst && !(WB_op == OP_I_ARTH && WB_rd == 5'd0);

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage: reset, load alignment,
// load data held across stalls, CSR writeback and flush-over-stall priority.
module tb_mem_wb_stage;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_CSR   = 7'b1110011;
   localparam logic [6:0] OP_NOP   = 7'b0010011;

   logic        clk = 1'b0;
   logic        rst, stall, flush;
   logic [6:0]  MEM_op;
   logic [4:0]  MEM_rd;
   logic [2:0]  MEM_funct3;
   logic [31:0] MEM_alu_out, MEM_pc4, DM_dout, CSR_dout;
   logic [11:0] MEM_CSR_imm;
   logic [6:0]  WB_op;
   logic [4:0]  WB_rd;
   logic [11:0] WB_CSR_imm;
   logic [31:0] WB_wdata;
   logic        WB_reg_we, WB_retire;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_wb_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .MEM_op(MEM_op), .MEM_rd(MEM_rd), .MEM_funct3(MEM_funct3),
      .MEM_alu_out(MEM_alu_out), .MEM_pc4(MEM_pc4), .MEM_CSR_imm(MEM_CSR_imm),
      .DM_dout(DM_dout), .CSR_dout(CSR_dout),
      .WB_op(WB_op), .WB_rd(WB_rd), .WB_CSR_imm(WB_CSR_imm),
      .WB_wdata(WB_wdata), .WB_reg_we(WB_reg_we), .WB_retire(WB_retire)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance past a rising edge; new inputs are then applied well clear of it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_mem(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3,
                          input logic [31:0] alu, input logic [31:0] pc4, input logic [11:0] imm);
      MEM_op = op; MEM_rd = rd; MEM_funct3 = f3;
      MEM_alu_out = alu; MEM_pc4 = pc4; MEM_CSR_imm = imm;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      DM_dout = '0; CSR_dout = '0;
      set_mem(7'd0, 5'd0, 3'd0, 32'h0, 32'h0, 12'h0);
      tick(); tick();
      rst = 1'b0;
      #1;
      check("rst_op",     {25'd0, WB_op}, {25'd0, OP_NOP});
      check("rst_rd",     {27'd0, WB_rd}, 32'd0);
      check("rst_we",     {31'd0, WB_reg_we}, 32'd0);
      check("rst_retire", {31'd0, WB_retire}, 32'd0);
      check("rst_wdata",  WB_wdata, 32'h0);

      // LB from byte 3, sign-extended
      set_mem(OP_LOAD, 5'd7, 3'b000, 32'h1003, 32'h0, 12'h0);
      tick();
      DM_dout = 32'h80FF1234;
      #1;
      check("lb_wdata",  WB_wdata, 32'hFFFFFF80);
      check("lb_we",     {31'd0, WB_reg_we}, 32'd1);
      check("lb_retire", {31'd0, WB_retire}, 32'd1);

      // LHU / LH from upper halfword
      set_mem(OP_LOAD, 5'd8, 3'b101, 32'h2002, 32'h0, 12'h0);
      tick();
      DM_dout = 32'h80010000;
      #1;
      check("lhu_wdata", WB_wdata, 32'h00008001);
      set_mem(OP_LOAD, 5'd8, 3'b001, 32'h2002, 32'h0, 12'h0);
      tick();
      #1;
      check("lh_wdata", WB_wdata, 32'hFFFF8001);

      // LW held across two stall cycles while the SRAM output changes
      set_mem(OP_LOAD, 5'd3, 3'b010, 32'h3000, 32'h0, 12'h0);
      tick();
      set_mem(OP_R, 5'd9, 3'b000, 32'h55, 32'h0, 12'h0);
      DM_dout = 32'hDEADBEEF; stall = 1'b1;
      #1;
      check("lw_st0_wdata",  WB_wdata, 32'hDEADBEEF);
      check("lw_st0_retire", {31'd0, WB_retire}, 32'd0);
      tick();
      DM_dout = 32'h0;
      #1;
      check("lw_st1_wdata",  WB_wdata, 32'hDEADBEEF);
      check("lw_st1_retire", {31'd0, WB_retire}, 32'd0);
      tick();
      DM_dout = 32'h5; stall = 1'b0;
      #1;
      check("lw_st2_wdata",  WB_wdata, 32'hDEADBEEF);
      check("lw_st2_rd",     {27'd0, WB_rd}, 32'd3);
      check("lw_st2_retire", {31'd0, WB_retire}, 32'd1);
      tick();
      #1;
      check("r_after_wdata", WB_wdata, 32'h55);
      check("r_after_rd",    {27'd0, WB_rd}, 32'd9);
      check("r_after_we",    {31'd0, WB_reg_we}, 32'd1);

      // CSR writeback, then with rd=0
      set_mem(OP_CSR, 5'd5, 3'b010, 32'h77, 32'h0, 12'hC00);
      tick();
      CSR_dout = 32'h00001234;
      #1;
      check("csr_imm",   {20'd0, WB_CSR_imm}, 32'h00000C00);
      check("csr_wdata", WB_wdata, 32'h00001234);
      check("csr_we",    {31'd0, WB_reg_we}, 32'd1);
      set_mem(OP_CSR, 5'd0, 3'b010, 32'h77, 32'h0, 12'hC00);
      tick();
      #1;
      check("csr_x0_we",     {31'd0, WB_reg_we}, 32'd0);
      check("csr_x0_retire", {31'd0, WB_retire}, 32'd1);

      // STORE never writes the register file
      set_mem(OP_STORE, 5'd4, 3'b010, 32'h10, 32'h0, 12'h0);
      tick();
      #1;
      check("store_we", {31'd0, WB_reg_we}, 32'd0);

      // JAL link value, then flush beats stall
      set_mem(OP_JAL, 5'd1, 3'b000, 32'h999, 32'h104, 12'h0);
      tick();
      #1;
      check("jal_wdata", WB_wdata, 32'h00000104);
      check("jal_we",    {31'd0, WB_reg_we}, 32'd1);
      stall = 1'b1; flush = 1'b1;
      #1;
      check("jal_stall_retire", {31'd0, WB_retire}, 32'd0);
      tick();
      stall = 1'b0; flush = 1'b0;
      #1;
      check("flush_op",     {25'd0, WB_op}, {25'd0, OP_NOP});
      check("flush_rd",     {27'd0, WB_rd}, 32'd0);
      check("flush_we",     {31'd0, WB_reg_we}, 32'd0);
      check("flush_retire", {31'd0, WB_retire}, 32'd0);
      check("flush_wdata",  WB_wdata, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
